// File: rtl/fl_alloc_ctrl_pkg.sv
// Shared sizes, types and helpers for the free-list dispatch allocation controller.
package fl_alloc_ctrl_pkg;

  localparam int WIDTH    = 2;
  localparam int FL_SIZE  = 32;
  localparam int NUM_CKPT = 4;

  localparam int PTR_W = $clog2(FL_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = $clog2(NUM_CKPT);

  typedef logic [TAG_W-1:0]    ckpt_tag_t;
  typedef logic [NUM_CKPT-1:0] ckpt_mask_t;
  typedef logic [PTR_W-1:0]    fl_ptr_t;
  typedef logic [CNT_W-1:0]    fl_cnt_t;

  typedef struct packed {
    logic       valid;
    fl_ptr_t    head_snap;
    ckpt_mask_t mask;
  } ckpt_entry_t;

  typedef enum logic {
    NORMAL,
    RECOVER
  } fl_state_e;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/fl_alloc_ctrl_if.sv
// Dispatch-stage handshake between the rename/dispatch logic and the allocation controller.
interface fl_alloc_ctrl_if
  import fl_alloc_ctrl_pkg::*;
();

  logic [WIDTH-1:0]          dispatch_req;
  logic [WIDTH-1:0]          dispatch_is_br;
  logic [WIDTH-1:0]          dispatch_grant;
  logic                      dispatch_stall;
  logic [WIDTH*TAG_W-1:0]    br_tag;
  logic [WIDTH*NUM_CKPT-1:0] br_mask;

  modport master (
    output dispatch_req, dispatch_is_br,
    input  dispatch_grant, dispatch_stall, br_tag, br_mask
  );

  modport slave (
    input  dispatch_req, dispatch_is_br,
    output dispatch_grant, dispatch_stall, br_tag, br_mask
  );

endinterface

// File: rtl/fl_ckpt_table.sv
// Branch checkpoint table: lowest-free allocation for two slots, correct-resolve release
// and mispredict squash of the resolved tag plus every checkpoint that depends on it.
module fl_ckpt_table
  import fl_alloc_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] alloc_en_i,
  input  fl_ptr_t          snap0_i,
  input  fl_ptr_t          snap1_i,
  input  logic             resolve_i,
  input  logic             mispredict_i,
  input  ckpt_tag_t        resolve_tag_i,
  output logic             avail_ge1_o,
  output logic             avail_ge2_o,
  output ckpt_tag_t        tag0_o,
  output ckpt_tag_t        tag1_o,
  output ckpt_mask_t       live_o,
  output ckpt_mask_t       mask0_o,
  output ckpt_mask_t       mask1_o,
  output fl_ptr_t          rec_snap_o
);

  ckpt_entry_t tbl_q [NUM_CKPT];
  ckpt_entry_t tbl_d [NUM_CKPT];

  ckpt_tag_t  first_tag, second_tag;
  logic       first_ok, second_ok;
  ckpt_mask_t tag0_bit, clr_bit;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latch).
    first_tag  = '0;
    second_tag = '0;
    first_ok   = 1'b0;
    second_ok  = 1'b0;
    live_o     = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      live_o[i] = tbl_q[i].valid;
      if (!tbl_q[i].valid) begin
        if (!first_ok) begin
          first_ok  = 1'b1;
          first_tag = TAG_W'(i);
        end else if (!second_ok) begin
          second_ok  = 1'b1;
          second_tag = TAG_W'(i);
        end
      end
    end
  end

  assign avail_ge1_o = first_ok;
  assign avail_ge2_o = second_ok;
  assign tag0_o      = first_tag;
  // Slot 1 takes the next free tag only when slot 0 is consuming the lowest one.
  assign tag1_o      = alloc_en_i[0] ? second_tag : first_tag;
  assign tag0_bit    = ckpt_mask_t'(1) << tag0_o;
  assign mask0_o     = live_o;
  assign mask1_o     = live_o | (alloc_en_i[0] ? tag0_bit : '0);
  assign rec_snap_o  = tbl_q[resolve_tag_i].head_snap;
  assign clr_bit     = (resolve_i && !mispredict_i) ? (ckpt_mask_t'(1) << resolve_tag_i) : '0;

  always_comb begin
    tbl_d = tbl_q;
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (resolve_i && ((TAG_W'(i) == resolve_tag_i) ||
                        (mispredict_i && tbl_q[i].mask[resolve_tag_i]))) begin
        tbl_d[i].valid = 1'b0;
      end
      tbl_d[i].mask = tbl_q[i].mask & ~clr_bit;
    end
    // Freshly allocated entries also drop a dependency resolved correctly this cycle.
    if (alloc_en_i[0]) tbl_d[tag0_o] = '{valid: 1'b1, head_snap: snap0_i, mask: mask0_o & ~clr_bit};
    if (alloc_en_i[1]) tbl_d[tag1_o] = '{valid: 1'b1, head_snap: snap1_i, mask: mask1_o & ~clr_bit};
  end

  always_ff @(posedge clock) begin
    // NOTE: the whole table is reset; valid bits gate allocation and stale masks would squash live entries.
    if (reset) begin
      for (int i = 0; i < NUM_CKPT; i++) tbl_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_CKPT; i++) tbl_q[i] <= tbl_d[i];
    end
  end

endmodule

// File: rtl/fl_alloc_ctrl.sv
// Dispatch-side free-list controller: in-order grants, occupancy/head tracking and a
// one-cycle mispredict recovery that rewinds the free list to a branch checkpoint.
module fl_alloc_ctrl
  import fl_alloc_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  fl_alloc_ctrl_if.slave   disp,
  input  logic [WIDTH-1:0] retire_en_i,
  input  logic             br_resolve_valid_i,
  input  ckpt_tag_t        br_resolve_tag_i,
  input  logic             br_mispredict_i,
  output logic             fl_rollback_en_o,
  output fl_ptr_t          fl_rewind_head_o,
  output fl_cnt_t          free_count_o
);

  fl_state_e state_q;
  fl_cnt_t   free_count_q, free_count_d, rec_count_d;
  fl_ptr_t   head_q, head_d;
  logic      rollback_q;
  fl_ptr_t   rewind_q;

  logic             resolve, mispredict;
  logic [WIDTH-1:0] grant, alloc_en;
  logic             avail_ge1, avail_ge2;
  ckpt_tag_t        tag0, tag1;
  ckpt_mask_t       live, mask0, mask1;
  fl_ptr_t          rec_snap, rec_dist;
  fl_cnt_t          grant_cnt, retire_cnt;
  logic [WIDTH*TAG_W-1:0] br_tag_w;

  // Resolves arriving during RECOVER are dropped; an assertion flags them.
  assign resolve    = (state_q == NORMAL) && br_resolve_valid_i;
  assign mispredict = resolve && br_mispredict_i;

  always_comb begin
    grant = '0;
    if (!reset && (state_q == NORMAL) && !mispredict) begin
      grant[0] = disp.dispatch_req[0] && (free_count_q >= CNT_W'(1)) &&
                 (!disp.dispatch_is_br[0] || avail_ge1);
      grant[1] = grant[0] && disp.dispatch_req[1] && (free_count_q >= CNT_W'(2)) &&
                 (!disp.dispatch_is_br[1] || (disp.dispatch_is_br[0] ? avail_ge2 : avail_ge1));
    end
  end

  assign alloc_en = grant & disp.dispatch_is_br;

  always_comb begin
    br_tag_w = '0;
    if (alloc_en[0]) br_tag_w[0     +: TAG_W] = tag0;
    if (alloc_en[1]) br_tag_w[TAG_W +: TAG_W] = tag1;
  end

  assign disp.dispatch_grant = grant;
  assign disp.dispatch_stall = |(disp.dispatch_req & ~grant);
  assign disp.br_tag         = br_tag_w;
  assign disp.br_mask        = {mask1, mask0};

  fl_ckpt_table u_ckpt_table (
    .clock         (clock),
    .reset         (reset),
    .alloc_en_i    (alloc_en),
    .snap0_i       (head_q + PTR_W'(1)),
    .snap1_i       (head_q + PTR_W'(2)),
    .resolve_i     (resolve),
    .mispredict_i  (br_mispredict_i),
    .resolve_tag_i (br_resolve_tag_i),
    .avail_ge1_o   (avail_ge1),
    .avail_ge2_o   (avail_ge2),
    .tag0_o        (tag0),
    .tag1_o        (tag1),
    .live_o        (live),
    .mask0_o       (mask0),
    .mask1_o       (mask1),
    .rec_snap_o    (rec_snap)
  );

  assign grant_cnt    = CNT_W'(popcount2(grant));
  assign retire_cnt   = CNT_W'(popcount2(retire_en_i));
  assign free_count_d = free_count_q - grant_cnt + retire_cnt;
  assign head_d       = head_q + PTR_W'(popcount2(grant));
  // Registers handed out after the checkpoint come back; the branch's own stays allocated.
  assign rec_dist     = head_q - rec_snap;
  assign rec_count_d  = free_count_q + CNT_W'(rec_dist) + retire_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= NORMAL;
      free_count_q <= CNT_W'(FL_SIZE);
      head_q       <= '0;
      rollback_q   <= 1'b0;
      rewind_q     <= '0;
    end else begin
      rollback_q <= 1'b0;
      rewind_q   <= '0;
      case (state_q)
        NORMAL: begin
          if (mispredict) begin
            state_q      <= RECOVER;
            head_q       <= rec_snap;
            free_count_q <= rec_count_d;
            rollback_q   <= 1'b1;
            rewind_q     <= rec_snap - PTR_W'(1);
          end else begin
            head_q       <= head_d;
            free_count_q <= free_count_d;
          end
        end
        RECOVER: begin
          state_q      <= NORMAL;
          free_count_q <= free_count_d;
        end
      endcase
    end
  end

  assign fl_rollback_en_o = rollback_q;
  assign fl_rewind_head_o = rewind_q;
  assign free_count_o     = free_count_q;

  a_no_resolve_in_recover: assert property (@(posedge clock) disable iff (reset)
    (state_q == RECOVER) |-> !br_resolve_valid_i);
  a_resolve_live_tag: assert property (@(posedge clock) disable iff (reset)
    resolve |-> live[br_resolve_tag_i]);
  a_count_bound: assert property (@(posedge clock) disable iff (reset)
    free_count_q <= CNT_W'(FL_SIZE));

endmodule

// File: tb/tb_fl_alloc_ctrl.sv
// Directed bench for fl_alloc_ctrl: fill/drain, low-count grants, checkpoint allocation,
// correct resolve, mispredict recovery, head wrap and reset during RECOVER.
module tb_fl_alloc_ctrl;

  logic       clock;
  logic       reset;
  logic [1:0] retire_en;
  logic       br_resolve_valid;
  logic [1:0] br_resolve_tag;
  logic       br_mispredict;
  logic       fl_rollback_en;
  logic [4:0] fl_rewind_head;
  logic [5:0] free_count;

  int n_cmp = 0;
  int n_bad = 0;

  fl_alloc_ctrl_if dif ();

  fl_alloc_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .disp               (dif),
    .retire_en_i        (retire_en),
    .br_resolve_valid_i (br_resolve_valid),
    .br_resolve_tag_i   (br_resolve_tag),
    .br_mispredict_i    (br_mispredict),
    .fl_rollback_en_o   (fl_rollback_en),
    .fl_rewind_head_o   (fl_rewind_head),
    .free_count_o       (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] is_br, input logic [1:0] ret,
                       input logic rvld = 1'b0, input logic [1:0] rtag = 2'd0,
                       input logic mpr = 1'b0);
    dif.dispatch_req   = req;
    dif.dispatch_is_br = is_br;
    retire_en          = ret;
    br_resolve_valid   = rvld;
    br_resolve_tag     = rtag;
    br_mispredict      = mpr;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_count",    free_count,         32);
    check("rst_rollback", fl_rollback_en,     0);
    check("rst_rewind",   fl_rewind_head,     0);
    check("rst_grant",    dif.dispatch_grant, 0);
    check("rst_stall",    dif.dispatch_stall, 0);
    check("rst_br_tag",   dif.br_tag,         0);
    check("rst_br_mask",  dif.br_mask,        0);

    // Drain all 32 registers two per cycle
    for (int k = 0; k < 16; k++) begin
      drive(2'b11, 2'b00, 2'b00);
      check("fill_grant", dif.dispatch_grant, 3);
      check("fill_count", free_count, 32 - 2 * k);
      tick();
    end
    check("empty_count", free_count,         0);
    check("empty_grant", dif.dispatch_grant, 0);
    check("empty_stall", dif.dispatch_stall, 1);

    // One free register: only slot 0; same-cycle retires land next cycle
    drive(2'b00, 2'b00, 2'b01);
    tick();
    check("one_count", free_count, 1);
    drive(2'b11, 2'b00, 2'b11);
    check("one_grant", dif.dispatch_grant, 1);
    check("one_stall", dif.dispatch_stall, 1);
    tick();
    check("one_retire_count", free_count, 2);

    // Checkpoint allocation until the table is full
    do_reset();
    drive(2'b11, 2'b11, 2'b00);
    check("br01_grant", dif.dispatch_grant, 3);
    check("br01_tag",   dif.br_tag,  4'h4);
    check("br01_mask",  dif.br_mask, 8'h10);
    tick();
    drive(2'b11, 2'b11, 2'b00);
    check("br23_tag",  dif.br_tag,  4'hE);
    check("br23_mask", dif.br_mask, 8'h73);
    tick();
    check("br_count", free_count, 28);
    drive(2'b01, 2'b01, 2'b00);
    check("full_grant", dif.dispatch_grant, 0);
    check("full_stall", dif.dispatch_stall, 1);
    // Mispredict tag 2 (snap 3, head 4) squashes 2 and 3 only
    drive(2'b01, 2'b00, 2'b00, 1'b1, 2'd2, 1'b1);
    check("mp2_grant", dif.dispatch_grant, 0);
    tick();
    check("mp2_rollback", fl_rollback_en,     1);
    check("mp2_rewind",   fl_rewind_head,     2);
    check("mp2_count",    free_count,         29);
    check("mp2_rec_grant", dif.dispatch_grant, 0);
    drive(2'b00, 2'b00, 2'b00);
    tick();
    check("mp2_rollback_off", fl_rollback_en, 0);
    drive(2'b11, 2'b11, 2'b00);
    check("mp2_realloc_grant", dif.dispatch_grant, 3);
    check("mp2_realloc_tag",   dif.br_tag,  4'hE);
    check("mp2_realloc_mask",  dif.br_mask, 8'h73);

    // Branch at head_snap 5, six younger allocations, mispredict with retires
    do_reset();
    drive(2'b11, 2'b00, 2'b00); tick();
    drive(2'b11, 2'b00, 2'b00); tick();
    drive(2'b01, 2'b01, 2'b00);
    check("snap5_grant", dif.dispatch_grant, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, 2'b00, 2'b00);
      tick();
    end
    check("snap5_count", free_count, 21);
    drive(2'b11, 2'b00, 2'b01, 1'b1, 2'd0, 1'b1);
    check("mp0_grant", dif.dispatch_grant, 0);
    tick();
    check("mp0_rollback", fl_rollback_en, 1);
    check("mp0_rewind",   fl_rewind_head, 4);
    check("mp0_count",    free_count,     28);
    drive(2'b11, 2'b00, 2'b10);
    check("mp0_rec_grant", dif.dispatch_grant, 0);
    tick();
    check("mp0_rollback_off", fl_rollback_en, 0);
    check("mp0_rec_count",    free_count,     29);
    drive(2'b11, 2'b11, 2'b00);
    check("mp0_after_grant", dif.dispatch_grant, 3);
    check("mp0_after_tag",   dif.br_tag,  4'h4);
    check("mp0_after_mask",  dif.br_mask, 8'h10);

    // Correct resolve clears the dependency so a reused tag 0 squashes alone
    do_reset();
    drive(2'b11, 2'b11, 2'b00); tick();
    drive(2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b0); tick();
    drive(2'b01, 2'b01, 2'b00);
    check("res_grant", dif.dispatch_grant, 1);
    check("res_tag",   dif.br_tag,  4'h0);
    check("res_mask",  dif.br_mask, 8'h32);
    tick();
    drive(2'b00, 2'b00, 2'b11, 1'b1, 2'd0, 1'b1);
    tick();
    check("res_mp0_rewind", fl_rewind_head, 2);
    check("res_mp0_count",  free_count,     31);
    drive(2'b00, 2'b00, 2'b00);
    tick();
    drive(2'b01, 2'b00, 2'b00);
    check("res_live1_mask", dif.br_mask, 8'h22);
    drive(2'b00, 2'b00, 2'b00, 1'b1, 2'd1, 1'b1);
    tick();
    check("res_mp1_rollback", fl_rollback_en, 1);
    check("res_mp1_rewind",   fl_rewind_head, 1);
    check("res_mp1_count",    free_count,     32);
    drive(2'b00, 2'b00, 2'b00);
    tick();
    drive(2'b01, 2'b00, 2'b00);
    check("res_none_mask", dif.br_mask, 8'h00);

    // Head wrap: snap 31, three younger allocations
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(2'b11, 2'b00, 2'b11);
      tick();
    end
    drive(2'b01, 2'b01, 2'b00);
    check("wrap_grant", dif.dispatch_grant, 1);
    tick();
    drive(2'b11, 2'b00, 2'b00); tick();
    drive(2'b01, 2'b00, 2'b00); tick();
    check("wrap_count", free_count, 28);
    drive(2'b00, 2'b00, 2'b00, 1'b1, 2'd0, 1'b1);
    tick();
    check("wrap_rollback", fl_rollback_en, 1);
    check("wrap_rewind",   fl_rewind_head, 30);
    check("wrap_count_rec", free_count,    31);

    // Reset while in RECOVER
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00);
    tick();
    reset = 1'b0;
    check("rrst_rollback", fl_rollback_en, 0);
    check("rrst_rewind",   fl_rewind_head, 0);
    check("rrst_count",    free_count,     32);
    drive(2'b11, 2'b11, 2'b00);
    check("rrst_grant", dif.dispatch_grant, 3);
    check("rrst_tag",   dif.br_tag, 4'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fl_alloc_ctrl.md
Name: fl_alloc_ctrl

Overview:
- Dispatch-side controller for the superscalar physical-register free list.
- Decides each cycle which dispatch slots may consume a free register, and produces the free list's per-slot dispatch enables.
- Keeps an occupancy count and a head-pointer mirror, plus a table of branch checkpoints.
- On a mispredict it sequences a one-cycle recovery: drives the free list's rollback_en/rewind_head and restores its own count.

Parameters:
- WIDTH, 2, dispatch/retire slots per cycle; only 2 is supported.
- FL_SIZE, 32, free-list entries; power of two.
- NUM_CKPT, 4, branch checkpoints in flight.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dispatch_req  in  WIDTH  slot i holds a valid instruction needing a dest preg
- dispatch_is_br  in  WIDTH  slot i is a branch and needs a checkpoint
- retire_en  in  WIDTH  slot i retires and returns a preg to the free list
- br_resolve_valid  in  1  branch resolved this cycle
- br_resolve_tag  in  $clog2(NUM_CKPT)  checkpoint tag of the resolved branch
- br_mispredict  in  1  qualifies br_resolve_valid
- dispatch_grant  out  WIDTH  slot i may dispatch; wired to the free list's dispatch_en
- dispatch_stall  out  1  some requesting slot was not granted
- br_tag  out  WIDTH*$clog2(NUM_CKPT)  tag assigned to a granted branch slot
- br_mask  out  WIDTH*NUM_CKPT  live-checkpoint mask each granted instruction depends on
- fl_rollback_en  out  1  to the free list
- fl_rewind_head  out  $clog2(FL_SIZE)  to the free list; the free list loads fl_rewind_head+1
- free_count  out  $clog2(FL_SIZE)+1  current free-register count

Behaviour:
- Reset values:
  - free_count=FL_SIZE; head mirror=0; all checkpoints invalid, masks 0.
  - state=NORMAL; fl_rollback_en=0; fl_rewind_head=0; grants 0; stall 0; br_tag/br_mask 0.
- FSM has two states, NORMAL and RECOVER.
  - NORMAL -> RECOVER on br_resolve_valid && br_mispredict.
  - RECOVER -> NORMAL unconditionally after 1 cycle.
- Grant logic is combinational and in order.
  - grant[0] requires all of:
    - state==NORMAL;
    - no mispredict this cycle;
    - dispatch_req[0];
    - free_count>=1;
    - if dispatch_is_br[0], at least one invalid checkpoint.
  - grant[1] requires all of:
    - grant[0];
    - dispatch_req[1];
    - free_count>=2;
    - enough invalid checkpoints for both slots' branches.
  - Slot 1 is never granted without slot 0.
- free_count and retires:
  - free_count is the registered value; same-cycle retires are not visible to grant.
  - Next value = free_count - popcount(grant) + popcount(retire_en).
- Head mirror advances by popcount(grant), modulo FL_SIZE.
- Checkpoint allocation:
  - Use the lowest-index invalid entry; slot 0 takes the lower tag when both slots are branches.
  - Entry stores:
    - head_snap = mirror head after allocations of slots up to and including that slot;
    - mask = checkpoints live at allocation, plus slot 0's new tag when slot 1 allocates.
- br_mask[i] = live checkpoints before this cycle, OR slot 0's new tag for slot 1. br_tag[i] is meaningful only when the slot is granted and is a branch.
- Correct resolve of tag t: invalidate t; clear bit t in every entry's mask. Takes effect next cycle.
- Mispredict of tag t, registered at the clock edge:
  - invalidate t and every entry whose mask has bit t;
  - head mirror <= head_snap[t];
  - free_count <= free_count + ((head - head_snap[t]) mod FL_SIZE) + popcount(retire_en);
  - fl_rollback_en=1 and fl_rewind_head=head_snap[t]-1 (mod FL_SIZE), both during the RECOVER cycle only.
- Retires during the mispredict cycle and the RECOVER cycle are counted normally.
- A br_resolve_valid during RECOVER is ignored; the resolver must not issue one, and an assertion checks this.
- A resolve of an invalid tag is an assertion error.
- free_count exceeding FL_SIZE is an assertion error.
- dispatch_stall = OR over i of (dispatch_req[i] && !dispatch_grant[i]).
- Reset mid-RECOVER returns everything to reset values next cycle.

Decomposition:
- Shared package: FL_SIZE, NUM_CKPT, WIDTH constants; ckpt_tag_t; ckpt_mask_t; a ckpt_entry_t struct (valid, head_snap, mask); a fl_state_e enum (NORMAL, RECOVER).
- One sub-module, fl_ckpt_table: the checkpoint storage with alloc, free and squash logic.
- Grant logic, counters and FSM stay in the top level.

Test Plan:
- Reset, then dispatch_req=11 every cycle with no retires -> grant=11 for 16 cycles; free_count 32->0; next cycle grant=00 and stall=1.
- free_count=1 with dispatch_req=11 -> grant=01, stall=1. Same cycle retire_en=11 -> free_count=2 next cycle.
- Dispatch branches in slots 0 and 1 together from empty checkpoints -> br_tag = 0 and 1; slot-1 mask = 0001. Two more branches, then a branch in slot 0 -> grant=00 (no checkpoint).
- Branch tag 0 at head_snap=5; dispatch 6 more; mispredict tag 0 -> next cycle fl_rollback_en=1, fl_rewind_head=4, free_count +6 (+ retires), tags 0 and younger invalid; grants 0 for two cycles.
- Correct resolve of tag 0 while tag 1 holds mask 0001 -> tag 1 mask becomes 0000; a later mispredict of tag 1 squashes only tag 1.
- Head wrap: head_snap=31 and a further 3 allocations, then mispredict -> fl_rewind_head=30; free_count restored +3.
